// File: rtl/motor_cmd_pkg.sv
// motor_cmd_pkg: parser states and packet field layout shared by the motor command dispatcher.
package motor_cmd_pkg;
    typedef enum logic [1:0] {S_HDR, S_PAY, S_CHK, S_COMMIT} state_t;
    localparam int CH_LSB    = 0;
    localparam int CH_MSB    = 3;
    localparam int CH_W      = CH_MSB - CH_LSB + 1;
    localparam int FLUSH_BIT = 7;
    localparam int DIV_LSB   = 4;
    localparam int HDR_BYTES = 1;
    localparam int PAY_BYTES = 4;
endpackage

// File: rtl/motor_cmd_queue.sv
// motor_cmd_queue: single-channel FIFO; flush overrides push/pop, a full queue accepts a push when popped the same cycle.
module motor_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [W-1:0]           din_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign count_o = cnt_q;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/motor_cmd_dispatcher.sv
// motor_cmd_dispatcher: parses UART command packets into per-channel motor queues.
// Define MOTOR_CMD_CHECKSUM_EN to require a trailing XOR checksum byte.
module motor_cmd_dispatcher
    import motor_cmd_pkg::*;
#(
    parameter int NUM_CH      = 10,
    parameter int QDEPTH      = 4,
    parameter int DIV_W       = 15,
    parameter int STEP_W      = 13,
    parameter int TIMEOUT_CYC = 24000
) (
    input  logic                     CLK_SE_AR,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_strobe,
    input  logic [NUM_CH-1:0]        ch_ready,
    output logic [NUM_CH-1:0]        ch_valid,
    output logic [NUM_CH*DIV_W-1:0]  ch_divider,
    output logic [NUM_CH*STEP_W-1:0] ch_steps,
    output logic [NUM_CH-1:0]        q_nonempty,
    output logic [NUM_CH-1:0]        q_full,
    output logic [NUM_CH-1:0]        ovf_sticky,
    input  logic                     ovf_clr,
    output logic [7:0]               err_count
);
    localparam int EW = DIV_W + STEP_W;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int IW = $clog2(PAY_BYTES);
    state_t                 state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic                   flush_q, flush_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [8*PAY_BYTES-1:0] word_q, word_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [7:0]             err_q, err_d;
    logic [NUM_CH-1:0]      ovf_q, ovf_d, push, pop, flsh, drop, full, empty;
    logic                   commit, bad, parse_err, err_inc;
    logic                   unused;
`ifdef MOTOR_CMD_CHECKSUM_EN
    logic [7:0]             chk_q, chk_d;
`endif
    assign commit    = state_q == S_COMMIT;
    assign bad       = {1'b0, ch_q} >= (CH_W+1)'(NUM_CH);
    assign err_inc   = parse_err | (commit & bad) | (|drop);
    assign err_d     = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    assign ovf_d     = (ovf_q & ~{NUM_CH{ovf_clr}}) | drop;
    assign unused    = ^{word_q[DIV_LSB-1:0], rx_data[6:4]};
    assign err_count = err_q;
    assign ovf_sticky = ovf_q;
    assign ch_valid   = ~empty;
    assign q_nonempty = ~empty;
    assign q_full     = full;
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        flush_d   = flush_q;
        idx_d     = idx_q;
        word_d    = word_q;
        tmo_d     = '0;
        parse_err = 1'b0;
`ifdef MOTOR_CMD_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        unique case (state_q)
            S_HDR: if (rx_strobe) begin
                ch_d    = rx_data[CH_MSB:CH_LSB];
                flush_d = rx_data[FLUSH_BIT];
                idx_d   = '0;
                state_d = S_PAY;
`ifdef MOTOR_CMD_CHECKSUM_EN
                chk_d   = rx_data;
`endif
            end
            S_PAY, S_CHK: if (rx_strobe) begin
                if (state_q == S_PAY) begin
                    word_d = {rx_data, word_q[8*PAY_BYTES-1:8]};
                    idx_d  = idx_q + 1'b1;
`ifdef MOTOR_CMD_CHECKSUM_EN
                    chk_d  = chk_q ^ rx_data;
                    if (idx_q == IW'(PAY_BYTES - 1)) state_d = S_CHK;
                end else begin
                    state_d   = rx_data == chk_q ? S_COMMIT : S_HDR;
                    parse_err = rx_data != chk_q;
`else
                    if (idx_q == IW'(PAY_BYTES - 1)) state_d = S_COMMIT;
                end else begin
                    state_d = S_HDR;
`endif
                end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d   = S_HDR;
                parse_err = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
            default: state_d = S_HDR;
        endcase
    end
    always_ff @(posedge CLK_SE_AR or posedge rst) begin
        if (rst) begin
            state_q <= S_HDR;
            ch_q    <= '0;
            flush_q <= 1'b0;
            idx_q   <= '0;
            word_q  <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
            ovf_q   <= '0;
`ifdef MOTOR_CMD_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            flush_q <= flush_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
`ifdef MOTOR_CMD_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end
    // Queue entries are stored as {steps, divider}, matching their order in the payload word.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [EW-1:0]           head;
        logic [$clog2(QDEPTH):0] cnt_unused;
        assign push[i] = commit & ~bad & ~flush_q & (ch_q == CH_W'(i));
        assign flsh[i] = commit & ~bad & flush_q & (ch_q == CH_W'(i));
        assign pop[i]  = ~empty[i] & ch_ready[i];
        assign drop[i] = push[i] & full[i] & ~pop[i];
        assign ch_divider[i*DIV_W +: DIV_W] = head[DIV_W-1:0];
        assign ch_steps[i*STEP_W +: STEP_W] = head[EW-1:DIV_W];
        motor_cmd_queue #(.DEPTH(QDEPTH), .W(EW)) u_q (
            .clk     (CLK_SE_AR),
            .rst     (rst),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .flush_i (flsh[i]),
            .din_i   (word_q[DIV_LSB +: EW]),
            .dout_o  (head),
            .count_o (cnt_unused),
            .full_o  (full[i]),
            .empty_o (empty[i])
        );
    end
endmodule
